// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encodings and bubble constants for the pipeline sequencer
package pipeline_ctrl_pkg;

    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // Encodings the pipeline registers load when flushed: all-zero word is sll $0,$0,0.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic        BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - debug, hazard and pipeline-control signal bundle for the sequencer
interface pipeline_ctrl_if #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 32
);
    logic              i_run;
    logic              i_step;
    logic [NB_REG-1:0] i_ID_rs;
    logic [NB_REG-1:0] i_ID_rt;
    logic              i_EX_mem_read;
    logic [NB_REG-1:0] i_EX_rt;
    logic              i_MEM_branch_taken;
    logic              i_ID_hlt;
    logic              i_WB_hlt;

    logic              o_pipe_en;
    logic              o_pc_en;
    logic              o_IF_ID_en;
    logic              o_IF_ID_flush;
    logic              o_ID_EX_flush;
    logic              o_EX_MEM_flush;
    logic              o_halted;
    logic [2:0]        o_state;
    logic [NB_CNT-1:0] o_cycle_count;
    logic [NB_CNT-1:0] o_stall_count;

    modport master (
        input  i_run, i_step, i_ID_rs, i_ID_rt, i_EX_mem_read, i_EX_rt,
               i_MEM_branch_taken, i_ID_hlt, i_WB_hlt,
        output o_pipe_en, o_pc_en, o_IF_ID_en, o_IF_ID_flush, o_ID_EX_flush,
               o_EX_MEM_flush, o_halted, o_state, o_cycle_count, o_stall_count
    );

    modport slave (
        output i_run, i_step, i_ID_rs, i_ID_rt, i_EX_mem_read, i_EX_rt,
               i_MEM_branch_taken, i_ID_hlt, i_WB_hlt,
        input  o_pipe_en, o_pc_en, o_IF_ID_en, o_IF_ID_flush, o_ID_EX_flush,
               o_EX_MEM_flush, o_halted, o_state, o_cycle_count, o_stall_count
    );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - combinational load-use hazard detector (load in EX feeding ID)
module load_use_detect #(
    parameter int NB_REG = 5
) (
    input  logic              i_EX_mem_read,
    input  logic [NB_REG-1:0] i_EX_rt,
    input  logic [NB_REG-1:0] i_ID_rs,
    input  logic [NB_REG-1:0] i_ID_rt,
    output logic              o_stall
);

    // $zero is never a real dependency, so a load targeting it cannot stall.
    assign o_stall = i_EX_mem_read
                   && (i_EX_rt != '0)
                   && ((i_EX_rt == i_ID_rs) || (i_EX_rt == i_ID_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer; optional stall counter under PIPELINE_CTRL_STALL_COUNT_EN
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    pipeline_ctrl_if.master   bus
);

    localparam logic [NB_CNT-1:0] CNT_MAX = '1;
    localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [NB_CNT-1:0] cycle_q, cycle_d;
    logic              load_use;
    logic              stall_apply;

    logic pipe_en, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, halted;

    load_use_detect #(.NB_REG(NB_REG)) u_load_use (
        .i_EX_mem_read (bus.i_EX_mem_read),
        .i_EX_rt       (bus.i_EX_rt),
        .i_ID_rs       (bus.i_ID_rs),
        .i_ID_rt       (bus.i_ID_rt),
        .o_stall       (load_use)
    );

    always_comb begin
        state_d      = state_q;
        pipe_en      = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;
        stall_apply  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_run) begin
                    state_d = ST_RUN;
                end else if (bus.i_step) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                pipe_en  = 1'b1;
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                // A taken branch squashes everything younger, including a stalled load consumer.
                if (bus.i_MEM_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_apply = 1'b1;
                end

                if (bus.i_ID_hlt && !bus.i_MEM_branch_taken && !load_use) begin
                    state_d = ST_DRAIN;
                end else if (state_q == ST_STEP) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                pipe_en     = 1'b1;
                if_id_flush = 1'b1;
                if (bus.i_WB_hlt) begin
                    state_d = ST_HALT;
                end else if (bus.i_MEM_branch_taken) begin
                    // The HLT was fetched down a mispredicted path; resume normal execution.
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_d      = ST_RUN;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cycle_d = (pipe_en && (cycle_q != CNT_MAX)) ? cycle_q + CNT_ONE : cycle_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
        end
    end

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    logic [NB_CNT-1:0] stall_q, stall_d;

    assign stall_d = (stall_apply && (stall_q != CNT_MAX)) ? stall_q + CNT_ONE : stall_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.o_stall_count = stall_q;
`else
    logic unused_stall_apply;

    assign unused_stall_apply = stall_apply;
    assign bus.o_stall_count  = '0;
`endif

    assign bus.o_pipe_en      = pipe_en;
    assign bus.o_pc_en        = pc_en;
    assign bus.o_IF_ID_en     = if_id_en;
    assign bus.o_IF_ID_flush  = if_id_flush;
    assign bus.o_ID_EX_flush  = id_ex_flush;
    assign bus.o_EX_MEM_flush = ex_mem_flush;
    assign bus.o_halted       = halted;
    assign bus.o_state        = state_q;
    assign bus.o_cycle_count  = cycle_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 0;
`endif

    pipeline_ctrl_if #(.NB_REG(5), .NB_CNT(32)) bus ();

    pipeline_ctrl #(.NB_REG(5), .NB_CNT(32)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.i_run = 0; bus.i_step = 0; bus.i_ID_rs = 0; bus.i_ID_rt = 0;
        bus.i_EX_mem_read = 0; bus.i_EX_rt = 0; bus.i_MEM_branch_taken = 0;
        bus.i_ID_hlt = 0; bus.i_WB_hlt = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", 32'(bus.o_state), 0);
        chk("rst_pipe_en", 32'(bus.o_pipe_en), 0);
        chk("rst_pc_en", 32'(bus.o_pc_en), 0);
        chk("rst_cycles", bus.o_cycle_count, 0);
        chk("rst_stalls", bus.o_stall_count, 0);

        rst = 0; bus.i_run = 1;
        #1 chk("idle_pipe_en", 32'(bus.o_pipe_en), 0);
        tick(); bus.i_run = 0;
        #1;
        chk("run_state", 32'(bus.o_state), 1);
        chk("run_pipe_en", 32'(bus.o_pipe_en), 1);
        chk("run_pc_en", 32'(bus.o_pc_en), 1);
        chk("run_if_id_en", 32'(bus.o_IF_ID_en), 1);
        chk("run_cycles0", bus.o_cycle_count, 0);
        repeat (10) tick();
        chk("run_cycles10", bus.o_cycle_count, 10);

        // load-use on rs
        bus.i_EX_mem_read = 1; bus.i_EX_rt = 8; bus.i_ID_rs = 8;
        #1;
        chk("lu_pc_en", 32'(bus.o_pc_en), 0);
        chk("lu_if_id_en", 32'(bus.o_IF_ID_en), 0);
        chk("lu_id_ex_flush", 32'(bus.o_ID_EX_flush), 1);
        chk("lu_if_id_flush", 32'(bus.o_IF_ID_flush), 0);
        tick();
        chk("lu_cycles", bus.o_cycle_count, 11);
        chk("lu_stalls", bus.o_stall_count, EXP_STALL);
        bus.i_EX_rt = 0; bus.i_ID_rs = 0;
        #1;
        chk("lu_r0_pc_en", 32'(bus.o_pc_en), 1);
        chk("lu_r0_id_ex_flush", 32'(bus.o_ID_EX_flush), 0);
        tick();

        // load-use on rt plus taken branch
        bus.i_EX_rt = 8; bus.i_ID_rs = 3; bus.i_ID_rt = 8; bus.i_MEM_branch_taken = 1;
        #1;
        chk("br_pc_en", 32'(bus.o_pc_en), 1);
        chk("br_if_id_flush", 32'(bus.o_IF_ID_flush), 1);
        chk("br_id_ex_flush", 32'(bus.o_ID_EX_flush), 1);
        chk("br_ex_mem_flush", 32'(bus.o_EX_MEM_flush), 1);
        tick();
        chk("br_stalls", bus.o_stall_count, EXP_STALL);
        chk("br_cycles", bus.o_cycle_count, 13);
        bus.i_EX_mem_read = 0; bus.i_EX_rt = 0; bus.i_ID_rt = 0; bus.i_ID_rs = 0;

        // HLT on wrong path is ignored
        bus.i_ID_hlt = 1;
        tick();
        chk("br_hlt_state", 32'(bus.o_state), 1);
        bus.i_MEM_branch_taken = 0;
        tick();
        chk("hlt_state", 32'(bus.o_state), 3);
        bus.i_ID_hlt = 0;
        #1;
        chk("drain_pc_en", 32'(bus.o_pc_en), 0);
        chk("drain_if_id_en", 32'(bus.o_IF_ID_en), 0);
        chk("drain_if_id_flush", 32'(bus.o_IF_ID_flush), 1);
        chk("drain_pipe_en", 32'(bus.o_pipe_en), 1);
        repeat (2) tick();
        bus.i_MEM_branch_taken = 1;
        #1;
        chk("drain_br_pc_en", 32'(bus.o_pc_en), 1);
        chk("drain_br_ex_mem", 32'(bus.o_EX_MEM_flush), 1);
        chk("drain_br_id_ex", 32'(bus.o_ID_EX_flush), 1);
        tick();
        bus.i_MEM_branch_taken = 0;
        chk("drain_br_state", 32'(bus.o_state), 1);
        chk("drain_br_cycles", bus.o_cycle_count, 18);

        // full drain to HALT
        bus.i_ID_hlt = 1;
        tick();
        bus.i_ID_hlt = 0;
        chk("hlt2_state", 32'(bus.o_state), 3);
        repeat (2) tick();
        bus.i_WB_hlt = 1;
        tick();
        bus.i_WB_hlt = 0;
        #1;
        chk("halt_state", 32'(bus.o_state), 4);
        chk("halt_halted", 32'(bus.o_halted), 1);
        chk("halt_pipe_en", 32'(bus.o_pipe_en), 0);
        chk("halt_pc_en", 32'(bus.o_pc_en), 0);
        chk("halt_cycles", bus.o_cycle_count, 22);
        bus.i_run = 1;
        repeat (3) tick();
        bus.i_run = 0;
        chk("halt_run_state", 32'(bus.o_state), 4);
        chk("halt_run_cycles", bus.o_cycle_count, 22);

        rst = 1;
        tick();
        rst = 0;
        chk("halt_rst_state", 32'(bus.o_state), 0);
        chk("halt_rst_cycles", bus.o_cycle_count, 0);
        chk("halt_rst_halted", 32'(bus.o_halted), 0);

        // single-step pulses four cycles apart
        for (int k = 0; k < 3; k++) begin
            bus.i_step = 1;
            tick();
            bus.i_step = 0;
            #1;
            chk("step_state", 32'(bus.o_state), 2);
            chk("step_pipe_en", 32'(bus.o_pipe_en), 1);
            tick();
            chk("step_back_idle", 32'(bus.o_state), 0);
            chk("step_idle_pipe_en", 32'(bus.o_pipe_en), 0);
            repeat (2) tick();
        end
        chk("step_cycles", bus.o_cycle_count, 3);

        // run and step together: run wins
        bus.i_run = 1; bus.i_step = 1;
        tick();
        bus.i_run = 0; bus.i_step = 0;
        chk("run_step_state", 32'(bus.o_state), 1);

        // reset while draining
        bus.i_ID_hlt = 1;
        tick();
        bus.i_ID_hlt = 0;
        chk("drain2_state", 32'(bus.o_state), 3);
        rst = 1;
        tick();
        rst = 0;
        chk("drain_rst_state", 32'(bus.o_state), 0);
        chk("drain_rst_cycles", bus.o_cycle_count, 0);
        chk("drain_rst_stalls", bus.o_stall_count, 0);

        // HLT during a step goes to DRAIN
        bus.i_step = 1;
        tick();
        bus.i_step = 0;
        bus.i_ID_hlt = 1;
        tick();
        bus.i_ID_hlt = 0;
        chk("step_hlt_state", 32'(bus.o_state), 3);
        chk("step_hlt_cycles", bus.o_cycle_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
